time_counter: RTL and testbench
===============================

# time_counter

Time-of-day and day-of-week counter that produces the current time consumed by the alarm comparator: `tmin`, `thrs` and `tdays` feed it directly. It advances on a one-cycle seconds strobe and carries seconds → minutes → hours → day-of-week. A set mode freezes timekeeping and lets the user step each field with edge-detected advance buttons. The day encoding is 0 = Sunday … 6 = Saturday, so days 0 and 6 are the weekend days the alarm's weekday logic excludes.

## Interface
Parameters: none. Field limits are fixed at 60 / 60 / 24 / 7.

- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset. Asserts immediately and releases synchronously to `clk`.
- `sec_tick` input 1: one-cycle strobe, nominally 1 Hz. Each high cycle is one second.
- `set_mode` input 1: level signal. While high, timekeeping is frozen and the advance inputs are live.
- `min_adv` input 1: level button, already debounced. Each rising edge advances the minute.
- `hrs_adv` input 1: level button. Each rising edge advances the hour.
- `day_adv` input 1: level button. Each rising edge advances the day.
- `tsec` output 7: seconds, 0–59.
- `tmin` output 7: minutes, 0–59.
- `thrs` output 7: hours, 0–23.
- `tdays` output 7: day of week, 0–6.
- `min_strobe` output 1: one-cycle pulse in the cycle after `tmin` changes value by any cause.

## Operation
- Reset: `tsec`, `tmin`, `thrs`, `tdays` = 0; `min_strobe` = 0; all edge-detect history registers = 0.
- Run mode (`set_mode` = 0, `sec_tick` = 1):
  - `tsec` increments.
  - At 59, `tsec` wraps to 0 and `tmin` increments.
  - At `tmin` 59 with a carry in, `tmin` wraps to 0 and `thrs` increments.
  - At `thrs` 23 with a carry in, `thrs` wraps to 0 and `tdays` increments.
  - At `tdays` 6 with a carry in, `tdays` wraps to 0.
- Run mode with `sec_tick` = 0: all fields hold.
- Set mode (`set_mode` = 1):
  - `sec_tick` is ignored; those ticks are dropped, not queued.
  - `tsec` is forced to 0 every cycle.
- Advance inputs:
  - Each has a registered previous-value copy; rising edge = current 1 and previous 0.
  - On a rising edge in set mode, the matching field increments by 1 and wraps at its limit: `tmin` 59→0, `thrs` 23→0, `tdays` 6→0.
  - No carry into the next field.
- Several advance edges in the same cycle: each affected field steps independently.
- Advance edges while `set_mode` = 0 are ignored. The history registers keep tracking in every mode, so a button held across entry into set mode produces no step until it is released and pressed again.
- Leaving set mode: counting resumes from `tsec` = 0 with the next `sec_tick`.
- Arithmetic: all fields are 7-bit unsigned with upper bits 0. Any value at or above a field's limit cannot occur after reset. If one is forced, the next increment of that field loads 0.
- `min_strobe` rises in the cycle after a run-mode minute carry or a set-mode `min_adv` step. It is never asserted in any other cycle.

## Timing
- Outputs are registered. A `sec_tick` high in cycle N is reflected on the outputs after edge N+1, and the full carry chain resolves in that same edge: no multi-cycle ripple.
- `min_strobe` is high for exactly the one cycle following the `tmin` update.
- An advance edge sampled at edge N updates the field at edge N+1. The press must be high for at least one cycle.
- `set_mode` and `sec_tick` high in the same cycle: set mode wins, and the tick is dropped.
- `set_mode` rising in cycle N: `tsec` reads 0 after edge N+1.
- `rst_n` low mid-count or mid-set: all outputs go to 0 immediately, without waiting for a clock edge. The first edge after release performs no increment, even if `sec_tick` is high.

## Test plan
- Reset, then 60 `sec_tick` pulses → `tsec` returns to 0, `tmin` = 1, `min_strobe` pulses once for one cycle.
- Preload 23:59:58, day 6, then 2 ticks → after 1st tick 23:59:59 day 6; after 2nd 00:00:00 day 0, with the outputs updating in the cycle after each tick.
- `set_mode` = 1 with `min_adv` pressed 61 times → `tmin` = 1 (wrapped once), `thrs` unchanged, `tsec` = 0. Ticks during this period cause no change.
- `hrs_adv` held high for 20 cycles → exactly one step. `day_adv` pressed at 6 → 0. `min_adv` pressed with `set_mode` = 0 → no change.
- `set_mode` and `sec_tick` both high in the same cycle at `tsec` = 30 → `tsec` = 0, no increment. After `set_mode` drops, one tick → `tsec` = 1.
- Assert `rst_n` low asynchronously mid-cycle at 12:34:56 day 3 → all outputs read 0 before the next edge. A tick coincident with release is ignored.

Source files
------------

// File: rtl/time_counter.sv
// Time-of-day and day-of-week counter feeding the alarm comparator.
// Latency: one clock from a sec_tick or advance press to the updated outputs;
//   the whole sec->min->hrs->day carry chain resolves in that single edge.
// Backpressure: none; ticks arriving in set mode are dropped, not queued.
//
// Ports:
//   clk, rst_n   clock and async active-low reset
//   sec_tick     one-cycle 1 Hz strobe, one second per high cycle
//   set_mode     level; freezes timekeeping and enables the advance buttons
//   min_adv      debounced level button, each rising edge steps the minute
//   hrs_adv      debounced level button, each rising edge steps the hour
//   day_adv      debounced level button, each rising edge steps the day
//   tsec         seconds 0-59
//   tmin         minutes 0-59
//   thrs         hours 0-23
//   tdays        day of week 0-6 (0 = Sunday)
//   min_strobe   one-cycle pulse while the freshly updated tmin is first visible
module time_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic       set_mode,
  input  logic       min_adv,
  input  logic       hrs_adv,
  input  logic       day_adv,
  output logic [6:0] tsec,
  output logic [6:0] tmin,
  output logic [6:0] thrs,
  output logic [6:0] tdays,
  output logic       min_strobe
);

  localparam logic [6:0] SEC_LAST = 7'd59;
  localparam logic [6:0] MIN_LAST = 7'd59;
  localparam logic [6:0] HRS_LAST = 7'd23;
  localparam logic [6:0] DAY_LAST = 7'd6;

  // Step a field by one; any value at or past its last legal value loads 0,
  // which also recovers from out-of-range values.
  function automatic logic [6:0] step(input logic [6:0] v, input logic [6:0] last);
    return (v >= last) ? 7'd0 : v + 7'd1;
  endfunction

  logic min_prev;
  logic hrs_prev;
  logic day_prev;
  // Cleared by reset and set by the first clock edge, so the edge that
  // releases reset never counts a tick or a press.
  logic run_ok;

  logic min_edge;
  logic hrs_edge;
  logic day_edge;
  logic sec_wrap;
  logic min_wrap;
  logic hrs_wrap;

  assign min_edge = min_adv & ~min_prev;
  assign hrs_edge = hrs_adv & ~hrs_prev;
  assign day_edge = day_adv & ~day_prev;

  assign sec_wrap = (tsec >= SEC_LAST);
  assign min_wrap = (tmin >= MIN_LAST);
  assign hrs_wrap = (thrs >= HRS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tsec       <= 7'd0;
      tmin       <= 7'd0;
      thrs       <= 7'd0;
      tdays      <= 7'd0;
      min_strobe <= 1'b0;
      min_prev   <= 1'b0;
      hrs_prev   <= 1'b0;
      day_prev   <= 1'b0;
      run_ok     <= 1'b0;
    end else begin
      run_ok <= 1'b1;
      // History follows the buttons in every mode, so a button already held
      // when set mode is entered must be released before it steps anything.
      min_prev   <= min_adv;
      hrs_prev   <= hrs_adv;
      day_prev   <= day_adv;
      min_strobe <= 1'b0;

      if (run_ok) begin
        if (set_mode) begin
          tsec <= 7'd0;
          if (min_edge) begin
            tmin       <= step(tmin, MIN_LAST);
            min_strobe <= 1'b1;
          end
          if (hrs_edge) thrs  <= step(thrs, HRS_LAST);
          if (day_edge) tdays <= step(tdays, DAY_LAST);
        end else if (sec_tick) begin
          tsec <= step(tsec, SEC_LAST);
          if (sec_wrap) begin
            tmin       <= step(tmin, MIN_LAST);
            min_strobe <= 1'b1;
            if (min_wrap) begin
              thrs <= step(thrs, HRS_LAST);
              if (hrs_wrap) tdays <= step(tdays, DAY_LAST);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_time_counter.sv
module tb_time_counter;

  logic       clk;
  logic       rst_n;
  logic       sec_tick;
  logic       set_mode;
  logic       min_adv;
  logic       hrs_adv;
  logic       day_adv;
  logic [6:0] tsec;
  logic [6:0] tmin;
  logic [6:0] thrs;
  logic [6:0] tdays;
  logic       min_strobe;

  int checks = 0;
  int errors = 0;
  int strobes;

  time_counter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sec_tick   (sec_tick),
    .set_mode   (set_mode),
    .min_adv    (min_adv),
    .hrs_adv    (hrs_adv),
    .day_adv    (day_adv),
    .tsec       (tsec),
    .tmin       (tmin),
    .thrs       (thrs),
    .tdays      (tdays),
    .min_strobe (min_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int s, input int m, input int h, input int d);
    chk({tag, ".sec"}, int'(tsec), s);
    chk({tag, ".min"}, int'(tmin), m);
    chk({tag, ".hrs"}, int'(thrs), h);
    chk({tag, ".day"}, int'(tdays), d);
  endtask

  // which: 0 = minute, 1 = hour, 2 = day. Each press is one cycle high, one low.
  task automatic press(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      case (which)
        0:       min_adv = 1'b1;
        1:       hrs_adv = 1'b1;
        default: day_adv = 1'b1;
      endcase
      cyc();
      min_adv = 1'b0;
      hrs_adv = 1'b0;
      day_adv = 1'b0;
      cyc();
    end
  endtask

  task automatic ticks(input int n);
    sec_tick = 1'b1;
    for (int i = 0; i < n; i++) cyc();
    sec_tick = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    sec_tick = 1'b0;
    set_mode = 1'b0;
    min_adv  = 1'b0;
    hrs_adv  = 1'b0;
    day_adv  = 1'b0;
    cyc();
    cyc();
    chk_time("reset", 0, 0, 0, 0);
    chk("reset.strobe", int'(min_strobe), 0);

    // Release with a tick already high: the first edge must not count.
    rst_n    = 1'b1;
    sec_tick = 1'b1;
    cyc();
    chk("release_tick.sec", int'(tsec), 0);

    // 60 seconds: one minute carry, exactly one strobe cycle.
    strobes = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (min_strobe) strobes++;
      if (i == 0) chk("first_tick.sec", int'(tsec), 1);
      if (i == 58) chk("tick59.min", int'(tmin), 0);
    end
    chk_time("sixty", 0, 1, 0, 0);
    chk("sixty.strobe_now", int'(min_strobe), 1);
    chk("sixty.strobe_count", strobes, 1);
    sec_tick = 1'b0;
    cyc();
    chk("hold.strobe", int'(min_strobe), 0);
    chk_time("hold", 0, 1, 0, 0);

    // Five seconds, then enter set mode with a tick in the same cycle.
    ticks(5);
    chk("five.sec", int'(tsec), 5);
    set_mode = 1'b1;
    sec_tick = 1'b1;
    cyc();
    chk_time("enter_set", 0, 1, 0, 0);

    // First minute press with ticks still running: step plus strobe.
    min_adv = 1'b1;
    cyc();
    chk("madv1.min", int'(tmin), 2);
    chk("madv1.strobe", int'(min_strobe), 1);
    min_adv = 1'b0;
    cyc();
    chk("madv1.strobe_off", int'(min_strobe), 0);
    // 60 more presses: 2 + 60 wraps back to 2.
    press(0, 60);
    chk_time("madv61", 0, 2, 0, 0);
    sec_tick = 1'b0;

    // Hour button held for 20 cycles gives one step.
    hrs_adv = 1'b1;
    cyc();
    chk("hold_hrs.first", int'(thrs), 1);
    for (int i = 0; i < 19; i++) cyc();
    chk("hold_hrs.20", int'(thrs), 1);
    hrs_adv = 1'b0;
    cyc();

    // Build 23:59 day 6, checking the day wrap on the way.
    press(1, 22);
    press(0, 57);
    press(2, 6);
    chk_time("preset", 0, 59, 23, 6);
    press(2, 1);
    chk("day_wrap", int'(tdays), 0);
    press(2, 6);

    // Leave set mode; a minute press now must do nothing.
    set_mode = 1'b0;
    cyc();
    min_adv = 1'b1;
    cyc();
    chk("run_madv.min", int'(tmin), 59);
    chk("run_madv.strobe", int'(min_strobe), 0);
    min_adv = 1'b0;
    cyc();

    // Counting resumes from 0; run to 23:59:58 then across the week boundary.
    sec_tick = 1'b1;
    cyc();
    chk("resume.sec", int'(tsec), 1);
    ticks(57);
    cyc();
    chk_time("pre_roll", 58, 59, 23, 6);
    sec_tick = 1'b1;
    cyc();
    chk_time("roll1", 59, 59, 23, 6);
    cyc();
    chk_time("roll2", 0, 0, 0, 0);
    chk("roll2.strobe", int'(min_strobe), 1);
    sec_tick = 1'b0;
    cyc();

    // Set mode and tick together at tsec 30: set wins.
    ticks(30);
    chk("thirty.sec", int'(tsec), 30);
    set_mode = 1'b1;
    sec_tick = 1'b1;
    cyc();
    chk("set_vs_tick.sec", int'(tsec), 0);
    set_mode = 1'b0;
    sec_tick = 1'b0;
    cyc();
    ticks(1);
    chk_time("after_set", 1, 0, 0, 0);

    // Day button held across entry into set mode: no step until re-pressed.
    day_adv = 1'b1;
    cyc();
    set_mode = 1'b1;
    cyc();
    cyc();
    chk("held_entry.day", int'(tdays), 0);
    day_adv = 1'b0;
    cyc();
    press(2, 1);
    chk("repress.day", int'(tdays), 1);

    // Build 12:34:56 day 3.
    press(1, 12);
    press(0, 34);
    press(2, 2);
    set_mode = 1'b0;
    cyc();
    ticks(56);
    cyc();
    chk_time("pre_reset", 56, 34, 12, 3);

    // Asynchronous reset between edges.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_time("async_rst", 0, 0, 0, 0);
    cyc();
    sec_tick = 1'b1;
    rst_n    = 1'b1;
    cyc();
    chk("rel_tick.sec", int'(tsec), 0);
    cyc();
    chk("post_rel.sec", int'(tsec), 1);
    sec_tick = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
